// File: rtl/corep_pkg.sv
// Shared core package: return-address-stack defaults and common typedefs.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package corep;

  localparam int RAS_ENTRIES = 8;
  localparam int PC_WIDTH    = 38;

  typedef logic [$clog2(RAS_ENTRIES)-1:0] RAS_idx_t;
  typedef logic [$clog2(RAS_ENTRIES):0]   RAS_cnt_t;
  typedef logic [PC_WIDTH-1:0]            PC_t;

endpackage

// File: rtl/ras_repair.sv
// Return address stack with checkpoint restore for branch-misprediction repair.
// Latency: outputs combinational from state; requests take effect at the next CLK edge.
// Backpressure: none; every request is accepted every cycle (update > link&ret > link > ret).
//
// Ports:
//   CLK, nRST                       clock, async active-low reset (clears stack, sp, count)
//   link_valid, link_pc             push a return address (call predicted)
//   ret_valid                       pop (return predicted)
//   ret_pc, ret_hit                 entry at sp; high when stack is non-empty
//   ret_ras_index, ret_ras_count    sp and occupancy, checkpointed by pc_gen
//   update_valid, update_ras_index,
//   update_ras_count, update_tos_pc restore sp/count from a checkpoint
//
// Build option: RAS_TOS_REPAIR_EN -- when defined, a restore also rewrites the
// top-of-stack entry with update_tos_pc, undoing a wrong-path overwrite of it.
module ras_repair #(
  parameter int RAS_ENTRIES = corep::RAS_ENTRIES,
  parameter int PC_WIDTH    = corep::PC_WIDTH
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic                           link_valid,
  input  logic [PC_WIDTH-1:0]            link_pc,
  input  logic                           ret_valid,
  output logic [PC_WIDTH-1:0]            ret_pc,
  output logic                           ret_hit,
  output logic [$clog2(RAS_ENTRIES)-1:0] ret_ras_index,
  output logic [$clog2(RAS_ENTRIES):0]   ret_ras_count,
  input  logic                           update_valid,
  input  logic [$clog2(RAS_ENTRIES)-1:0] update_ras_index,
  input  logic [$clog2(RAS_ENTRIES):0]   update_ras_count,
  input  logic [PC_WIDTH-1:0]            update_tos_pc
);

  localparam int IDX_W = $clog2(RAS_ENTRIES);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_ENTRIES);

  logic [PC_WIDTH-1:0] stack_q [RAS_ENTRIES];
  logic [IDX_W-1:0]    sp_q, sp_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Single write port into the array, decoded one-hot in the register block.
  logic                wr_en;
  logic [IDX_W-1:0]    wr_idx;
  logic [PC_WIDTH-1:0] wr_dat;

`ifndef RAS_TOS_REPAIR_EN
  // Checkpointed TOS value only matters when the repair write is built in.
  logic unused_tos_pc;
  assign unused_tos_pc = ^update_tos_pc;
`endif

  always_comb begin
    sp_d   = sp_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = sp_q;
    wr_dat = link_pc;

    if (update_valid) begin
      sp_d  = update_ras_index;
      cnt_d = (update_ras_count > CNT_MAX) ? CNT_MAX : update_ras_count;
`ifdef RAS_TOS_REPAIR_EN
      wr_en  = 1'b1;
      wr_idx = update_ras_index;
      wr_dat = update_tos_pc;
`endif
    end else if (link_valid && ret_valid) begin
      // Return then call in one cycle: the new return address replaces TOS.
      wr_en = 1'b1;
    end else if (link_valid) begin
      // sp wraps, so a push on a full stack overwrites the oldest entry.
      wr_en  = 1'b1;
      wr_idx = sp_q + 1'b1;
      sp_d   = sp_q + 1'b1;
      cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end else if (ret_valid) begin
      // sp keeps moving on underflow so it stays consistent with older pushes.
      sp_d  = sp_q - 1'b1;
      cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_ENTRIES; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < RAS_ENTRIES; i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) begin
          stack_q[i] <= wr_dat;
        end
      end
    end
  end

  assign ret_pc        = stack_q[sp_q];
  assign ret_ras_index = sp_q;
  assign ret_ras_count = cnt_q;
  assign ret_hit       = (cnt_q != '0);

endmodule

// File: tb/tb_ras_repair.sv
module tb_ras_repair;
  import corep::*;

`ifdef RAS_TOS_REPAIR_EN
  localparam bit REPAIR = 1'b1;
`else
  localparam bit REPAIR = 1'b0;
`endif

  logic     CLK;
  logic     nRST;
  logic     link_valid;
  PC_t      link_pc;
  logic     ret_valid;
  PC_t      ret_pc;
  logic     ret_hit;
  RAS_idx_t ret_ras_index;
  RAS_cnt_t ret_ras_count;
  logic     update_valid;
  RAS_idx_t update_ras_index;
  RAS_cnt_t update_ras_count;
  PC_t      update_tos_pc;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic     lv;
    PC_t      lpc;
    logic     rv;
    logic     uv;
    RAS_idx_t ui;
    RAS_cnt_t uc;
    PC_t      upc;
  } stim_t;

  typedef struct packed {
    logic     hit;
    RAS_idx_t idx;
    RAS_cnt_t cnt;
    PC_t      pc;
    logic     chk_pc;
  } exp_t;

  exp_t exp_q[$];

  ras_repair dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .link_valid       (link_valid),
    .link_pc          (link_pc),
    .ret_valid        (ret_valid),
    .ret_pc           (ret_pc),
    .ret_hit          (ret_hit),
    .ret_ras_index    (ret_ras_index),
    .ret_ras_count    (ret_ras_count),
    .update_valid     (update_valid),
    .update_ras_index (update_ras_index),
    .update_ras_count (update_ras_count),
    .update_tos_pc    (update_tos_pc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic stim_t s_push(input PC_t pc);
    return '{lv: 1'b1, lpc: pc, rv: 1'b0, uv: 1'b0, ui: '0, uc: '0, upc: '0};
  endfunction

  function automatic stim_t s_pop();
    return '{lv: 1'b0, lpc: '0, rv: 1'b1, uv: 1'b0, ui: '0, uc: '0, upc: '0};
  endfunction

  function automatic stim_t s_linkret(input PC_t pc);
    return '{lv: 1'b1, lpc: pc, rv: 1'b1, uv: 1'b0, ui: '0, uc: '0, upc: '0};
  endfunction

  function automatic stim_t s_upd(input RAS_idx_t ui, input RAS_cnt_t uc, input PC_t upc);
    return '{lv: 1'b0, lpc: '0, rv: 1'b0, uv: 1'b1, ui: ui, uc: uc, upc: upc};
  endfunction

  function automatic exp_t ex(input int cnt, input int idx, input PC_t pc, input logic chk);
    return '{hit: (cnt != 0), idx: RAS_idx_t'(idx), cnt: RAS_cnt_t'(cnt), pc: pc, chk_pc: chk};
  endfunction

  // Drive one cycle of requests; returns #1 after the edge that consumed them.
  task automatic step(input stim_t s);
    link_valid       = s.lv;
    link_pc          = s.lpc;
    ret_valid        = s.rv;
    update_valid     = s.uv;
    update_ras_index = s.ui;
    update_ras_count = s.uc;
    update_tos_pc    = s.upc;
    @(posedge CLK);
    #1;
    link_valid   = 1'b0;
    ret_valid    = 1'b0;
    update_valid = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    link_valid = 1'b0; link_pc = '0; ret_valid = 1'b0;
    update_valid = 1'b0; update_ras_index = '0; update_ras_count = '0; update_tos_pc = '0;
    #1;
    checks++;
    if ({ret_hit, ret_ras_index, ret_ras_count, ret_pc} !== {1'b0, 3'd0, 4'd0, 38'h0}) begin
      errors++;
      $display("FAIL reset_during: hit=%0b idx=%0d cnt=%0d pc=%h, expected all zero",
               ret_hit, ret_ras_index, ret_ras_count, ret_pc);
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    checks++;
    if ({ret_hit, ret_ras_index, ret_ras_count, ret_pc} !== {1'b0, 3'd0, 4'd0, 38'h0}) begin
      errors++;
      $display("FAIL reset_after: hit=%0b idx=%0d cnt=%0d pc=%h, expected all zero",
               ret_hit, ret_ras_index, ret_ras_count, ret_pc);
    end
  endtask

  task automatic test_push_pop();
    stim_t sq[$];
    exp_t  eq[$];
    exp_t  e;
    sq.push_back(s_push(38'h100)); eq.push_back(ex(1, 1, 38'h100, 1'b1));
    sq.push_back(s_push(38'h200)); eq.push_back(ex(2, 2, 38'h200, 1'b1));
    sq.push_back(s_push(38'h300)); eq.push_back(ex(3, 3, 38'h300, 1'b1));
    sq.push_back(s_pop());         eq.push_back(ex(2, 2, 38'h200, 1'b1));
    sq.push_back(s_pop());         eq.push_back(ex(1, 1, 38'h100, 1'b1));
    sq.push_back(s_pop());         eq.push_back(ex(0, 0, 38'h0,   1'b1));
    foreach (sq[i]) begin
      exp_q.push_back(eq[i]);
      step(sq[i]);
      e = exp_q.pop_front();
      checks++;
      if (ret_hit !== e.hit || ret_ras_index !== e.idx || ret_ras_count !== e.cnt ||
          (e.chk_pc && ret_pc !== e.pc)) begin
        errors++;
        $display("FAIL push_pop step %0d: hit=%0b idx=%0d cnt=%0d pc=%h, expected hit=%0b idx=%0d cnt=%0d pc=%h",
                 i, ret_hit, ret_ras_index, ret_ras_count, ret_pc, e.hit, e.idx, e.cnt, e.pc);
      end
    end
  endtask

  task automatic test_overflow();
    stim_t sq[$];
    exp_t  eq[$];
    exp_t  e;
    PC_t   pc;
    for (int k = 1; k <= 9; k++) begin
      sq.push_back(s_push(PC_t'(k)));
      eq.push_back(ex((k > 8) ? 8 : k, k % 8, PC_t'(k), 1'b1));
    end
    // Slot 1 now holds 0x9 (overwrote 0x1) and slot 0 holds 0x8.
    for (int j = 1; j <= 9; j++) begin
      pc = (j <= 7) ? PC_t'(9 - j) : ((j == 8) ? 38'h9 : 38'h8);
      sq.push_back(s_pop());
      eq.push_back(ex((j <= 8) ? 8 - j : 0, (9 - j) % 8, pc, 1'b1));
    end
    foreach (sq[i]) begin
      exp_q.push_back(eq[i]);
      step(sq[i]);
      e = exp_q.pop_front();
      checks++;
      if (ret_hit !== e.hit || ret_ras_index !== e.idx || ret_ras_count !== e.cnt ||
          (e.chk_pc && ret_pc !== e.pc)) begin
        errors++;
        $display("FAIL overflow step %0d: hit=%0b idx=%0d cnt=%0d pc=%h, expected hit=%0b idx=%0d cnt=%0d pc=%h",
                 i, ret_hit, ret_ras_index, ret_ras_count, ret_pc, e.hit, e.idx, e.cnt, e.pc);
      end
    end
  endtask

  task automatic test_link_ret();
    stim_t sq[$];
    exp_t  eq[$];
    exp_t  e;
    sq.push_back(s_push(38'h10));    eq.push_back(ex(2 - 1, 1, 38'h10, 1'b1));
    sq.push_back(s_push(38'h20));    eq.push_back(ex(2, 2, 38'h20, 1'b1));
    sq.push_back(s_linkret(38'h30)); eq.push_back(ex(2, 2, 38'h30, 1'b1));
    sq.push_back(s_pop());           eq.push_back(ex(1, 1, 38'h10, 1'b1));
    sq.push_back(s_pop());           eq.push_back(ex(0, 0, 38'h0,  1'b0));
    foreach (sq[i]) begin
      exp_q.push_back(eq[i]);
      step(sq[i]);
      e = exp_q.pop_front();
      checks++;
      if (ret_hit !== e.hit || ret_ras_index !== e.idx || ret_ras_count !== e.cnt ||
          (e.chk_pc && ret_pc !== e.pc)) begin
        errors++;
        $display("FAIL link_ret step %0d: hit=%0b idx=%0d cnt=%0d pc=%h, expected hit=%0b idx=%0d cnt=%0d pc=%h",
                 i, ret_hit, ret_ras_index, ret_ras_count, ret_pc, e.hit, e.idx, e.cnt, e.pc);
      end
    end
  endtask

  task automatic test_repair();
    stim_t sq[$];
    exp_t  eq[$];
    exp_t  e;
    // Checkpoint taken after the second push: index 2, count 2, tos 0x20.
    sq.push_back(s_push(38'h10)); eq.push_back(ex(1, 1, 38'h10, 1'b1));
    sq.push_back(s_push(38'h20)); eq.push_back(ex(2, 2, 38'h20, 1'b1));
    sq.push_back(s_push(38'h50)); eq.push_back(ex(3, 3, 38'h50, 1'b1));
    sq.push_back(s_pop());        eq.push_back(ex(2, 2, 38'h20, 1'b1));
    sq.push_back(s_pop());        eq.push_back(ex(1, 1, 38'h10, 1'b1));
    sq.push_back(s_push(38'h60)); eq.push_back(ex(2, 2, 38'h60, 1'b1));
    sq.push_back(s_push(38'h70)); eq.push_back(ex(3, 3, 38'h70, 1'b1));
    sq.push_back(s_upd(3'd2, 4'd2, 38'h20));
    eq.push_back(ex(2, 2, REPAIR ? 38'h20 : 38'h60, 1'b1));
    // Out-of-range checkpoint count saturates at the stack depth.
    sq.push_back(s_upd(3'd5, 4'd15, 38'h77));
    eq.push_back(ex(8, 5, 38'h77, REPAIR));
    sq.push_back(s_upd(3'd4, 4'd8, 38'h44));
    eq.push_back(ex(8, 4, 38'h44, REPAIR));
    foreach (sq[i]) begin
      exp_q.push_back(eq[i]);
      step(sq[i]);
      e = exp_q.pop_front();
      checks++;
      if (ret_hit !== e.hit || ret_ras_index !== e.idx || ret_ras_count !== e.cnt ||
          (e.chk_pc && ret_pc !== e.pc)) begin
        errors++;
        $display("FAIL repair step %0d: hit=%0b idx=%0d cnt=%0d pc=%h, expected hit=%0b idx=%0d cnt=%0d pc=%h",
                 i, ret_hit, ret_ras_index, ret_ras_count, ret_pc, e.hit, e.idx, e.cnt, e.pc);
      end
    end
  endtask

  task automatic test_update_priority();
    stim_t sq[$];
    exp_t  eq[$];
    exp_t  e;
    stim_t both;
    sq.push_back(s_upd(3'd0, 4'd0, 38'h0)); eq.push_back(ex(0, 0, 38'h0, REPAIR));
    sq.push_back(s_push(38'h11));           eq.push_back(ex(1, 1, 38'h11, 1'b1));
    sq.push_back(s_push(38'h22));           eq.push_back(ex(2, 2, 38'h22, 1'b1));
    sq.push_back(s_pop());                  eq.push_back(ex(1, 1, 38'h11, 1'b1));
    // Update together with link and ret: the push must not touch slot 2.
    both     = s_upd(3'd1, 4'd1, 38'h11);
    both.lv  = 1'b1;
    both.lpc = 38'hBB;
    both.rv  = 1'b1;
    sq.push_back(both);                     eq.push_back(ex(1, 1, 38'h11, 1'b1));
    // Walk sp down past empty (no writes) until it wraps round to slot 2.
    for (int j = 1; j <= 7; j++) begin
      sq.push_back(s_pop());
      eq.push_back(ex(0, (9 - j) % 8, 38'h22, (j == 7)));
    end
    foreach (sq[i]) begin
      exp_q.push_back(eq[i]);
      step(sq[i]);
      e = exp_q.pop_front();
      checks++;
      if (ret_hit !== e.hit || ret_ras_index !== e.idx || ret_ras_count !== e.cnt ||
          (e.chk_pc && ret_pc !== e.pc)) begin
        errors++;
        $display("FAIL update_priority step %0d: hit=%0b idx=%0d cnt=%0d pc=%h, expected hit=%0b idx=%0d cnt=%0d pc=%h",
                 i, ret_hit, ret_ras_index, ret_ras_count, ret_pc, e.hit, e.idx, e.cnt, e.pc);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    // Set up a live push, then pull reset between edges.
    link_valid = 1'b1;
    link_pc    = 38'h99;
    #2;
    nRST = 1'b0;
    #1;
    checks++;
    if ({ret_hit, ret_ras_index, ret_ras_count, ret_pc} !== {1'b0, 3'd0, 4'd0, 38'h0}) begin
      errors++;
      $display("FAIL reset_mid_async: hit=%0b idx=%0d cnt=%0d pc=%h, expected all zero",
               ret_hit, ret_ras_index, ret_ras_count, ret_pc);
    end
    @(posedge CLK);
    #1;
    checks++;
    if ({ret_hit, ret_ras_index, ret_ras_count, ret_pc} !== {1'b0, 3'd0, 4'd0, 38'h0}) begin
      errors++;
      $display("FAIL reset_mid_req: hit=%0b idx=%0d cnt=%0d pc=%h, expected all zero",
               ret_hit, ret_ras_index, ret_ras_count, ret_pc);
    end
    @(negedge CLK);
    link_valid = 1'b0;
    nRST = 1'b1;
    // Slot 7 held 0x7 before reset; a pop from empty exposes whether it was cleared.
    exp_q.push_back(ex(0, 7, 38'h0, 1'b1));
    step(s_pop());
    e = exp_q.pop_front();
    checks++;
    if (ret_hit !== e.hit || ret_ras_index !== e.idx || ret_ras_count !== e.cnt ||
        (e.chk_pc && ret_pc !== e.pc)) begin
      errors++;
      $display("FAIL reset_mid_clear: hit=%0b idx=%0d cnt=%0d pc=%h, expected hit=%0b idx=%0d cnt=%0d pc=%h",
               ret_hit, ret_ras_index, ret_ras_count, ret_pc, e.hit, e.idx, e.cnt, e.pc);
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_link_ret();
    test_repair();
    test_update_priority();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
